// File: rtl/ram_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, one clock.
// Same-address read and write in one cycle returns the new data (write-first); reset clears all storage.
module ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_next;

    // Write-first bypass: a same-address write overrides the stored word.
    always_comb begin
        // NOTE: the default assignment comes first so every path drives rd_next and no latch is inferred.
        rd_next = mem[rd_addr];
        if (wr_enb && (wr_addr == rd_addr)) begin
            rd_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: clearing the array on reset keeps it in flops rather than a RAM macro; that is the intended trade here.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            // NOTE: non-blocking assignments make mem and rd_data update together on the edge, so mem[rd_addr] still reads the old word.
            if (wr_enb) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_enb) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Self-checking bench for ram_sdp: directed steps plus random traffic against an array reference model.
module tb_ram_sdp;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_enb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_enb;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_sdp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_enb(wr_enb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_enb(rd_enb),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] expected);
        checks++;
        assert (rd_data === expected) else begin
            errors++;
            $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, expected);
        end
    endtask

    // One clock cycle: drive on the falling edge, advance the model, check rd_data just after the rising edge.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re,
                        input logic [AW-1:0] ra, input string tag);
        @(negedge clk);
        rst     = r;
        wr_enb  = we;
        wr_addr = wa;
        wr_data = wd;
        rd_enb  = re;
        rd_addr = ra;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_rd = '0;
        end else begin
            if (re) model_rd = (we && wa == ra) ? wd : model_mem[ra];
            if (we) model_mem[wa] = wd;
        end
        #1;
        check(tag, model_rd);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        step(1'b0, 1'b1, a, d, 1'b0, '0, tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        step(1'b0, 1'b0, '0, '0, 1'b1, a, tag);
    endtask

    initial begin
        logic          r_r, r_we, r_re;
        logic [AW-1:0] r_wa, r_ra;
        logic [DW-1:0] r_wd;

        rst = 1'b1; wr_enb = 1'b0; rd_enb = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        model_rd = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

        // 1. Reset with enables asserted (must be ignored), then read every address.
        step(1'b1, 1'b1, 4'd5, 8'h77, 1'b1, 4'd5, "rst_cycle0");
        check("rst_zero0", 8'h00);
        step(1'b1, 1'b1, 4'd6, 8'h88, 1'b1, 4'd6, "rst_cycle1");
        check("rst_zero1", 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), "rst_read");
            check("rst_read_zero", 8'h00);
        end

        // 2. Basic write then read.
        wr(4'd3, 8'hA5, "t2_wr3");
        wr(4'd15, 8'h3C, "t2_wr15");
        rd(4'd3, "t2_rd3");
        check("t2_rd3_val", 8'hA5);
        rd(4'd15, "t2_rd15");
        check("t2_rd15_val", 8'h3C);

        // 3. Same-address read during write is write-first.
        step(1'b0, 1'b1, 4'd7, 8'h5A, 1'b1, 4'd7, "t3_rdw");
        check("t3_rdw_val", 8'h5A);

        // 4. rd_data holds while rd_enb is low, even as the word underneath changes.
        rd(4'd3, "t4_rd3");
        check("t4_rd3_val", 8'hA5);
        for (int i = 0; i < 3; i++) begin
            wr(4'd3, 8'hFF, "t4_hold");
            check("t4_hold_val", 8'hA5);
        end
        rd(4'd3, "t4_rd3_new");
        check("t4_rd3_new_val", 8'hFF);

        // 5. Full sweep.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(16 - i), "t5_wr");
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), "t5_rd");
            check("t5_rd_val", DW'(16 - i));
        end
        rd(4'd0, "t5_rd0");
        check("t5_rd0_val", 8'h10);

        // 6. Reset in the middle of back-to-back writes.
        wr(4'd1, 8'h11, "t6_wr1");
        wr(4'd2, 8'h22, "t6_wr2");
        step(1'b1, 1'b1, 4'd4, 8'h33, 1'b0, '0, "t6_rst");
        check("t6_rst_zero", 8'h00);
        wr(4'd5, 8'h44, "t6_wr5");
        rd(4'd1, "t6_rd1");
        check("t6_rd1_val", 8'h00);
        rd(4'd2, "t6_rd2");
        check("t6_rd2_val", 8'h00);
        rd(4'd4, "t6_rd4");
        check("t6_rd4_val", 8'h00);
        rd(4'd5, "t6_rd5");
        check("t6_rd5_val", 8'h44);

        // Random traffic with frequent address collisions and occasional resets.
        for (int n = 0; n < 400; n++) begin
            r_r  = ($urandom_range(0, 59) == 0);
            r_we = $urandom_range(0, 1) == 1;
            r_re = $urandom_range(0, 3) != 0;
            r_wa = AW'($urandom_range(0, DEPTH - 1));
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, DEPTH - 1));
            r_wd = DW'($urandom);
            step(r_r, r_we, r_wa, r_wd, r_re, r_ra, "rand");
        end

        // Final sweep of the whole array against the model.
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), "final_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
